// File: rtl/fp21_pack.sv
// FP21 result packer: unpacked {sign, signed exp, frac+hidden} -> packed 21-bit word, buffered in a show-ahead FIFO.
// Optional build macro FP21_PACK_SATURATE_EN: overflow packs max finite instead of infinity.
module fp21_pack #(
  parameter int EXP_W      = 7,
  parameter int FRAC_W     = 13,
  parameter int BIAS       = 63,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sign_in,
  input  logic [EXP_W:0]            exp_in,
  input  logic [FRAC_W:0]           frac_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     word_out,
  output logic                      ovf_flag,
  output logic                      unf_flag,
  input  logic                      flag_clr
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [EXP_W+1:0] EXP_INF = (EXP_W+2)'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_OVF, CLS_UNF} cls_t;

  // Stage 1 inputs: re-biased exponent and classification
  logic signed [EXP_W+1:0] be;
  cls_t                    cls_d;

  always_comb begin
    be = $signed({exp_in[EXP_W], exp_in}) + $signed((EXP_W+2)'(BIAS));
    cls_d = CLS_NORM;
    if (!frac_in[FRAC_W])
      cls_d = CLS_ZERO;
    else if (be >= EXP_INF)
      cls_d = CLS_OVF;
    else if (be[EXP_W+1] || be == '0)
      cls_d = CLS_UNF;
  end

  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [FRAC_W-1:0] s1_frac;
  cls_t              s1_cls;

  logic              in_fire;
  assign in_fire = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_cls   <= CLS_ZERO;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_sign <= sign_in;
        s1_exp  <= be[EXP_W-1:0];
        s1_frac <= frac_in[FRAC_W-1:0];
        s1_cls  <= cls_d;
      end
    end
  end

  // Stage 2: assemble the packed word
  logic [W-1:0] word_d;

  always_comb begin
    word_d = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
    case (s1_cls)
      CLS_NORM: word_d = {s1_sign, s1_exp, s1_frac};
`ifdef FP21_PACK_SATURATE_EN
      CLS_OVF:  word_d = {s1_sign, EXP_W'((1 << EXP_W) - 2), {FRAC_W{1'b1}}};
`else
      CLS_OVF:  word_d = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`endif
      default:  word_d = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
    endcase
  end

  logic         s2_valid;
  logic [W-1:0] s2_word;
  logic         s2_ovf;
  logic         s2_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_ovf   <= 1'b0;
      s2_unf   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_word  <= word_d;
      s2_ovf   <= s1_valid && s1_cls == CLS_OVF;
      s2_unf   <= s1_valid && s1_cls == CLS_UNF;
    end
  end

  // Output FIFO; in_ready reserves a slot for every word still in the pipeline
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] occ;
  logic          push;
  logic          pop;

  assign push      = s2_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign word_out  = out_valid ? mem[rd_ptr] : '0;
  assign occ       = {1'b0, count} + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
  assign in_ready  = occ < (AW+2)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s2_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
      ovf_flag <= (ovf_flag & ~flag_clr) | (push & s2_ovf);
      unf_flag <= (unf_flag & ~flag_clr) | (push & s2_unf);
    end
  end

endmodule

// File: tb/tb_fp21_pack.sv
// Self-checking bench for fp21_pack: vector table, scoreboard of expected words, and
// hand-written sequences for latency, backpressure, throughput, sticky flags and reset.
module tb_fp21_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [13:0] frac_in;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] word_out;
  logic        ovf_flag;
  logic        unf_flag;
  logic        flag_clr;

  int checks = 0;
  int errors = 0;
  logic [20:0] sb[$];

`ifdef FP21_PACK_SATURATE_EN
  localparam logic [20:0] OVF_POS = 21'h0FDFFF;
  localparam logic [20:0] OVF_NEG = 21'h1FDFFF;
`else
  localparam logic [20:0] OVF_POS = 21'h0FE000;
  localparam logic [20:0] OVF_NEG = 21'h1FE000;
`endif

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [13:0] f;
    logic [20:0] w;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[10];

  fp21_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .frac_in(frac_in),
    .out_valid(out_valid), .out_ready(out_ready), .word_out(word_out),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every popped word must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word actual=%0h expected=none", word_out);
      end else begin
        checkOutput("word", {11'b0, word_out}, {11'b0, sb.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [13:0] f, input logic [20:0] w);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=in_ready0 expected=in_ready1");
      return;
    end
    sign_in  = s;
    exp_in   = e;
    frac_in  = f;
    in_valid = 1'b1;
    sb.push_back(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("drain_left", sb.size(), 0);
  endtask

  task automatic pulseClr();
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int acc;
    logic [20:0] head;

    vecs[0] = '{1'b0, 8'd0,    14'h2000, 21'h07E000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'd1,    14'h2800, 21'h180800, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'd5,    14'h0000, 21'h100000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'd64,   14'h3FFF, OVF_POS,    1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'hC1,   14'h2000, 21'h100000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'hC2,   14'h2001, 21'h002001, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'hC0,   14'h3000, 21'h000000, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'd63,   14'h3FFF, 21'h1FDFFF, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'd127,  14'h2000, OVF_NEG,    1'b1, 1'b0};
    vecs[9] = '{1'b0, 8'd100,  14'h1FFF, 21'h000000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; frac_in = '0;
    out_ready = 1'b1; flag_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_word_out", word_out, 0);
    checkOutput("rst_ovf", ovf_flag, 0);
    checkOutput("rst_unf", unf_flag, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    // Latency: out_valid appears on the third edge counting the accept edge
    sign_in = 1'b0; exp_in = 8'd0; frac_in = 14'h2000; in_valid = 1'b1;
    sb.push_back(21'h07E000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("latency", n, 3);
    drain();

    foreach (vecs[i]) begin
      pulseClr();
      applyStimulus(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].w);
      drain();
      checkOutput($sformatf("ovf_flag_v%0d", i), ovf_flag, vecs[i].ovf);
      checkOutput($sformatf("unf_flag_v%0d", i), unf_flag, vecs[i].unf);
    end

    pulseClr();
    checkOutput("ovf_cleared", ovf_flag, 0);

    // Flag set while flag_clr is held: set must win on the push cycle
    flag_clr = 1'b1;
    applyStimulus(1'b0, 8'd64, 14'h3FFF, OVF_POS);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("set_wins", ovf_flag, 1);
    @(posedge clk); #1;
    checkOutput("clr_after_set", ovf_flag, 0);
    flag_clr = 1'b0;
    drain();

    // Backpressure: only FIFO_DEPTH accepts while the sink is stalled
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      logic took;
      sign_in = 1'b0; exp_in = 8'(acc); frac_in = 14'h2000 | 14'(acc);
      in_valid = 1'b1;
      took = in_ready;
      if (took)
        sb.push_back({1'b0, 7'(63 + acc), 13'(acc)});
      @(posedge clk); #1;
      if (took) acc++;
    end
    in_valid = 1'b0;
    checkOutput("bp_accepts", acc, 4);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    head = 21'h07E000;
    checkOutput("bp_hold_word", word_out, head);
    out_ready = 1'b1;
    for (int i = acc; i < 8; i++)
      applyStimulus(1'b0, 8'(i), 14'h2000 | 14'(i), {1'b0, 7'(63 + i), 13'(i)});
    drain();

    // Throughput: back-to-back accepts with the sink always ready
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      logic took;
      sign_in = 1'b1; exp_in = 8'(c + 2); frac_in = 14'h2100 + 14'(c);
      in_valid = 1'b1;
      took = in_ready;
      if (took)
        sb.push_back({1'b1, 7'(65 + c), 13'h0100 + 13'(c)});
      @(posedge clk); #1;
      if (took) acc++;
    end
    in_valid = 1'b0;
    checkOutput("throughput", acc, 8);
    drain();

    // Reset with the FIFO full and a sticky flag set
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'd0, 14'h2000, 21'h07E000);
    applyStimulus(1'b0, 8'd1, 14'h2000, 21'h080000);
    applyStimulus(1'b1, 8'd0, 14'h2000, 21'h17E000);
    applyStimulus(1'b0, 8'd64, 14'h3FFF, OVF_POS);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_ovf", ovf_flag, 1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_word", word_out, 0);
    checkOutput("mid_rst_ovf", ovf_flag, 0);
    checkOutput("mid_rst_unf", unf_flag, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("post_rst_no_words", out_valid, 0);

    applyStimulus(1'b1, 8'd1, 14'h2800, 21'h180800);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
